// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard unit: shadow EX/MEM destination slots, operand bypass selects, load-use stall.
// Define HAZARD_STALL_CNT_EN to add the stall_cnt output and its wrapping counter.
module hazard_fwd_unit #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rd,
    input  logic                      id_reg_write_en,
    input  logic                      id_is_load,
    input  logic                      IF_flush,
    output logic [1:0]                forward_comp1,
    output logic [1:0]                forward_comp2,
    output logic                      pc_write,
    output logic                      IF_ID_write,
    output logic                      ID_EX_bubble,
    output logic                      IF_flush_gated
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr;
        logic                      load;
    } slot_t;

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic stall;

    always_comb begin
        ex_m1  = ex_q.valid  & ex_q.wr  & (ex_q.rd  == IF_ID_rs1) & (ex_q.rd  != '0) & id_uses_rs1;
        ex_m2  = ex_q.valid  & ex_q.wr  & (ex_q.rd  == IF_ID_rs2) & (ex_q.rd  != '0) & id_uses_rs2;
        mem_m1 = mem_q.valid & mem_q.wr & (mem_q.rd == IF_ID_rs1) & (mem_q.rd != '0) & id_uses_rs1;
        mem_m2 = mem_q.valid & mem_q.wr & (mem_q.rd == IF_ID_rs2) & (mem_q.rd != '0) & id_uses_rs2;

        stall = id_valid & ex_q.load & (ex_m1 | ex_m2);

        forward_comp1 = 2'b00;
        forward_comp2 = 2'b00;
        // An EX match that survives the stall check is always an ALU result.
        if (id_valid && !stall) begin
            if (ex_m1)       forward_comp1 = 2'b01;
            else if (mem_m1) forward_comp1 = mem_q.load ? 2'b10 : 2'b11;
            if (ex_m2)       forward_comp2 = 2'b01;
            else if (mem_m2) forward_comp2 = mem_q.load ? 2'b10 : 2'b11;
        end

        pc_write       = ~stall;
        IF_ID_write    = ~stall;
        ID_EX_bubble   = stall;
        IF_flush_gated = IF_flush & ~stall;

        mem_d = ex_q;
        ex_d  = '0;
        if (!stall) begin
            ex_d.valid = id_valid;
            ex_d.rd    = IF_ID_rd;
            ex_d.wr    = id_reg_write_en;
            ex_d.load  = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, stall};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed hazard scenarios plus random stimulus against a history-queue model.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write_en, id_is_load, IF_flush;
    logic [1:0] forward_comp1, forward_comp2;
    logic       pc_write, IF_ID_write, ID_EX_bubble, IF_flush_gated;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_fwd_unit #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .IF_ID_rd(IF_ID_rd), .id_reg_write_en(id_reg_write_en), .id_is_load(id_is_load),
        .IF_flush(IF_flush),
        .forward_comp1(forward_comp1), .forward_comp2(forward_comp2),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
        .IF_flush_gated(IF_flush_gated)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the last two instructions issued past ID, newest first.
    typedef struct packed {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       load;
    } rec_t;

    rec_t        hist[$];
    bit   [1:0]  exp_fwd1, exp_fwd2;
    bit          exp_stall;
    int unsigned model_cnt;

    function automatic bit produces(rec_t r, bit [4:0] s, bit uses);
        return r.valid && r.wr && (r.rd == s) && (r.rd != 0) && uses;
    endfunction

    function automatic bit [1:0] pick(rec_t ex, rec_t mem, bit [4:0] s, bit uses);
        if (produces(ex, s, uses))  return 2'd1;
        if (produces(mem, s, uses)) return mem.load ? 2'd2 : 2'd3;
        return 2'd0;
    endfunction

    function automatic void model_eval();
        rec_t ex, mem;
        ex  = (hist.size() > 0) ? hist[0] : '0;
        mem = (hist.size() > 1) ? hist[1] : '0;
        exp_stall = id_valid && ex.load &&
                    (produces(ex, IF_ID_rs1, id_uses_rs1) || produces(ex, IF_ID_rs2, id_uses_rs2));
        exp_fwd1 = (id_valid && !exp_stall) ? pick(ex, mem, IF_ID_rs1, id_uses_rs1) : 2'd0;
        exp_fwd2 = (id_valid && !exp_stall) ? pick(ex, mem, IF_ID_rs2, id_uses_rs2) : 2'd0;
    endfunction

    function automatic void model_reset();
        hist.delete();
        model_cnt = 0;
    endfunction

    task automatic tick();
        rec_t r;
        model_eval();
        @(posedge clk);
        r = '0;
        if (!exp_stall) r = '{valid: id_valid, rd: IF_ID_rd, wr: id_reg_write_en, load: id_is_load};
        if (exp_stall) model_cnt++;
        hist.push_front(r);
        if (hist.size() > 2) void'(hist.pop_back());
        #1;
    endtask

    task automatic set_id(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                          input bit u2, input bit [4:0] rd, input bit wr, input bit ld, input bit fl);
        id_valid = v; IF_ID_rs1 = r1; id_uses_rs1 = u1; IF_ID_rs2 = r2; id_uses_rs2 = u2;
        IF_ID_rd = rd; id_reg_write_en = wr; id_is_load = ld; IF_flush = fl;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'($urandom_range(7)), 1, 5'($urandom_range(7)), 1, 5'($urandom_range(7)), 1, 1, 1'(i & 1));
            @(negedge clk);
            n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL rst_pc_write got %0b want 1", pc_write); end
            n_cmp++; if (IF_ID_write !== 1'b1) begin n_err++; $display("FAIL rst_ifid_write got %0b want 1", IF_ID_write); end
            n_cmp++; if (ID_EX_bubble !== 1'b0) begin n_err++; $display("FAIL rst_bubble got %0b want 0", ID_EX_bubble); end
            n_cmp++; if ({forward_comp1, forward_comp2} !== 4'b0) begin n_err++; $display("FAIL rst_sel got %b/%b want 00/00", forward_comp1, forward_comp2); end
            n_cmp++; if (IF_flush_gated !== IF_flush) begin n_err++; $display("FAIL rst_flush got %0b want %0b", IF_flush_gated, IF_flush); end
`ifdef HAZARD_STALL_CNT_EN
            n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
`endif
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_alu_bypass();
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        set_id(1, 5, 1, 1, 1, 8, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if (forward_comp1 !== 2'b01) begin n_err++; $display("FAIL alu_ex_sel got %b want 01", forward_comp1); end
        n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL alu_no_stall got %0b want 1", pc_write); end
        tick();
        set_id(1, 5, 1, 0, 0, 9, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if (forward_comp1 !== 2'b11) begin n_err++; $display("FAIL alu_mem_sel got %b want 11", forward_comp1); end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        set_id(1, 1, 1, 7, 1, 10, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if ({pc_write, IF_ID_write, ID_EX_bubble} !== 3'b001) begin n_err++; $display("FAIL lu_stall got pc/ifid/bub=%b%b%b want 001", pc_write, IF_ID_write, ID_EX_bubble); end
        n_cmp++; if (forward_comp2 !== 2'b00) begin n_err++; $display("FAIL lu_stall_sel got %b want 00", forward_comp2); end
        tick();
        @(negedge clk);
        n_cmp++; if (forward_comp2 !== 2'b10) begin n_err++; $display("FAIL lu_dmem_sel got %b want 10", forward_comp2); end
        n_cmp++; if ({pc_write, ID_EX_bubble} !== 2'b10) begin n_err++; $display("FAIL lu_resume got pc/bub=%b%b want 10", pc_write, ID_EX_bubble); end
`ifdef HAZARD_STALL_CNT_EN
        n_cmp++; if (stall_cnt !== model_cnt) begin n_err++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, model_cnt); end
`endif
        tick();
        drain();
    endtask

    task automatic test_x0_uses();
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++; if ({forward_comp1, forward_comp2} !== 4'b0) begin n_err++; $display("FAIL x0_sel got %b/%b want 00/00", forward_comp1, forward_comp2); end
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        set_id(1, 2, 1, 5, 0, 11, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if ({pc_write, ID_EX_bubble} !== 2'b10) begin n_err++; $display("FAIL uses_no_stall got pc/bub=%b%b want 10", pc_write, ID_EX_bubble); end
        n_cmp++; if (forward_comp2 !== 2'b00) begin n_err++; $display("FAIL uses_sel got %b want 00", forward_comp2); end
        tick();
        drain();
    endtask

    task automatic test_priority();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        set_id(1, 3, 1, 3, 1, 12, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if ({forward_comp1, forward_comp2} !== 4'b0101) begin n_err++; $display("FAIL prio_sel got %b/%b want 01/01", forward_comp1, forward_comp2); end
        tick();
        drain();
    endtask

    task automatic test_stall_flush();
        set_id(1, 0, 0, 0, 0, 4, 1, 1, 0);
        tick();
        set_id(1, 4, 1, 0, 0, 13, 0, 0, 1);
        @(negedge clk);
        n_cmp++; if (IF_flush_gated !== 1'b0) begin n_err++; $display("FAIL sf_gated_stall got %0b want 0", IF_flush_gated); end
        n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL sf_pc_stall got %0b want 0", pc_write); end
        tick();
        @(negedge clk);
        n_cmp++; if (IF_flush_gated !== 1'b1) begin n_err++; $display("FAIL sf_gated_next got %0b want 1", IF_flush_gated); end
        n_cmp++; if (forward_comp1 !== 2'b10) begin n_err++; $display("FAIL sf_sel_next got %b want 10", forward_comp1); end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 0);
        tick();
        set_id(1, 9, 1, 0, 0, 14, 1, 0, 1);
        @(negedge clk);
        n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL rms_pre_stall got %0b want 0", pc_write); end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({pc_write, IF_ID_write, ID_EX_bubble} !== 3'b110) begin n_err++; $display("FAIL rms_in_reset got pc/ifid/bub=%b%b%b want 110", pc_write, IF_ID_write, ID_EX_bubble); end
        n_cmp++; if (IF_flush_gated !== 1'b1) begin n_err++; $display("FAIL rms_flush got %0b want 1", IF_flush_gated); end
        @(posedge clk); #1;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if ({pc_write, ID_EX_bubble, forward_comp1} !== 4'b1000) begin n_err++; $display("FAIL rms_after got pc/bub/sel1=%b%b%b want 1000", pc_write, ID_EX_bubble, forward_comp1); end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            set_id(($urandom_range(9) != 0),
                   5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)), 1'($urandom),
                   5'($urandom_range(7)), ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
            @(negedge clk);
            model_eval();
            n_cmp++;
            if ({forward_comp1, forward_comp2, pc_write, IF_ID_write, ID_EX_bubble, IF_flush_gated} !==
                {exp_fwd1, exp_fwd2, !exp_stall, !exp_stall, exp_stall, IF_flush && !exp_stall}) begin
                n_err++;
                $display("FAIL rnd_%0d got sel=%b/%b pc=%b ifid=%b bub=%b fl=%b want sel=%b/%b stall=%b fl=%b",
                         i, forward_comp1, forward_comp2, pc_write, IF_ID_write, ID_EX_bubble, IF_flush_gated,
                         exp_fwd1, exp_fwd2, exp_stall, IF_flush && !exp_stall);
            end
            tick();
        end
`ifdef HAZARD_STALL_CNT_EN
        @(negedge clk);
        n_cmp++; if (stall_cnt !== model_cnt) begin n_err++; $display("FAIL rnd_stall_cnt got %0d want %0d", stall_cnt, model_cnt); end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_alu_bypass();
        test_load_use();
        test_x0_uses();
        test_priority();
        test_stall_flush();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
